rob_multi_commit: RTL
=====================

Name: rob_multi_commit

Overview:
- Parametrised reorder buffer: next generation of the single-retire ROB.
- Allocates one instruction per cycle at the tail.
- Accepts result writeback on CDB_PORTS independent ports.
- Retires up to COMMIT_W entries per cycle in program order; squashes younger entries when a taken branch resolves.
- Sits between decode/issue, the functional units (writeback) and the register file, store path and reg-status table (commit).

Parameters:
- RB_SIZE, 8, entry count; power of two, >=4.
- RB_INDEX, 3, log2(RB_SIZE).
- WORD_SIZE, 32, data/address width.
- REG_INDEX, 5, register number width.
- CDB_PORTS, 2, writeback ports.
- COMMIT_W, 2, max retirements per cycle (1..4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- alloc_valid  in  1  allocation request.
- alloc_kind  in  2  00 reg-write, 01 store, 10 branch, 11 halt.
- alloc_rdest  in  REG_INDEX  destination register (reg-write only).
- alloc_ready  out  1  combinational: count<RB_SIZE && !halted && !flush_cond.
- alloc_idx  out  RB_INDEX  combinational: tail index the next allocation receives.
- wb_valid  in  CDB_PORTS  per-port writeback strobe.
- wb_idx  in  CDB_PORTS*RB_INDEX  target entry per port.
- wb_data  in  CDB_PORTS*WORD_SIZE  result; for branches bit0=taken.
- wb_addr  in  CDB_PORTS*WORD_SIZE  store address / branch target.
- mem_ready  in  1  store path accepts a store this cycle.
- commit_valid  out  COMMIT_W  registered, per slot, slot 0 oldest.
- commit_kind  out  COMMIT_W*2  per slot.
- commit_rdest  out  COMMIT_W*REG_INDEX  per slot.
- commit_data  out  COMMIT_W*WORD_SIZE  per slot.
- commit_addr  out  COMMIT_W*WORD_SIZE  per slot.
- commit_idx  out  COMMIT_W*RB_INDEX  retired entry index (for reg-status clear).
- flush  out  1  registered one-cycle pulse on taken branch.
- redirect_pc  out  WORD_SIZE  target valid with flush.
- halted  out  1  sticky after halt retires.

Behaviour:
- Reset (reset==0 at edge): head=tail=count=0; all entries invalid/not-done; commit_valid=0, flush=0, halted=0, redirect_pc=0, other commit_* =0.
- Entry state: valid, done, kind, rdest, data, addr.
- Allocate when alloc_valid&&alloc_ready at edge: entry[tail] valid, done=0 (halt entries done=1); tail=tail+1 mod RB_SIZE.
- Writeback: each port with wb_valid and entry valid sets done, data, addr at the edge.
  - Writes to invalid entries are ignored.
  - Two ports to the same index: lower port wins.
- Entry done at edge N is retirable at edge N+1; commit_* visible during the cycle after N+1. No same-edge bypass.
- Retire at edge, from pre-edge state, slot k=0..COMMIT_W-1 over entry head+k: retires iff all earlier slots retired, entry valid && done, and:
  - store: only in slot 0 and only when mem_ready==1;
  - halt: retires alone in its slot and ends the scan.
  - Retired entries are invalidated; head advances by the number retired; commit_valid bits are contiguous from slot 0.
  - Branch entries retire with commit_kind=10; consumers ignore them.
- Taken branch (flush_cond): a wb port writes a valid branch entry with wb_data[0]=1.
  - If several in one cycle, the oldest (smallest (idx-head) mod RB_SIZE) wins.
  - At the edge: entries strictly younger than the branch are invalidated; tail=branch_idx+1; count recomputed; flush=1 and redirect_pc=wb_addr next cycle.
  - alloc_ready=0 while flush_cond, so no allocation is lost.
  - Writebacks in the same cycle to squashed entries are discarded.
  - The branch itself completes normally.
- Retire and flush in the same cycle both take effect; retirement only touches entries older than or equal to the branch.
- Full (count==RB_SIZE): alloc_ready=0; retirement still proceeds.
- Pointers wrap modulo RB_SIZE. count holds 0..RB_SIZE in RB_INDEX+1 bits. Allocation and retirement in the same cycle update count by +1-r.
- Halt: after it retires, halted=1; no further allocation or retirement until reset.
- Reset mid-operation: reset dominates all same-edge allocation, writeback and flush.

Test Plan:
- Alloc 3 reg-writes (r1,r2,r3); wb idx2 then idx0,idx1 same cycle (data 5,6) -> next edge commits r1=5,r2=6 (commit_valid=11); following edge commits r3; head=3.
- Fill 8 entries -> alloc_ready=0 at count=8; complete idx0 -> one retire, alloc_ready=1; tail wraps to 0 on next alloc.
- Store at head, done, mem_ready=0 for 3 cycles -> no commits; mem_ready=1 -> store commits in slot 0 only, a done reg-write behind it waits one more cycle.
- Entries idx1..5, branch at idx2 wb taken target 0x40 -> flush pulse, redirect_pc=0x40, tail=3, idx3..5 invalid; wb to idx4 same cycle ignored.
- Taken branches idx4 and idx2 on ports 0/1 same cycle with head=1 -> idx2 wins, tail=3.
- Halt after two done reg-writes -> both commit, halt commits, halted=1, alloc_ready stuck 0; reset low one edge -> all outputs 0, count=0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer that allocates one entry per cycle, takes
// results on CDB_PORTS writeback ports, retires up to COMMIT_W entries per
// cycle in program order and squashes younger entries on a taken branch.
module rob_multi_commit #(
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5,
  parameter int CDB_PORTS = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  input  logic [1:0]                     alloc_kind,
  input  logic [REG_INDEX-1:0]           alloc_rdest,
  output logic                           alloc_ready,
  output logic [RB_INDEX-1:0]            alloc_idx,
  input  logic [CDB_PORTS-1:0]           wb_valid,
  input  logic [CDB_PORTS*RB_INDEX-1:0]  wb_idx,
  input  logic [CDB_PORTS*WORD_SIZE-1:0] wb_data,
  input  logic [CDB_PORTS*WORD_SIZE-1:0] wb_addr,
  input  logic                           mem_ready,
  output logic [COMMIT_W-1:0]            commit_valid,
  output logic [COMMIT_W*2-1:0]          commit_kind,
  output logic [COMMIT_W*REG_INDEX-1:0]  commit_rdest,
  output logic [COMMIT_W*WORD_SIZE-1:0]  commit_data,
  output logic [COMMIT_W*WORD_SIZE-1:0]  commit_addr,
  output logic [COMMIT_W*RB_INDEX-1:0]   commit_idx,
  output logic                           flush,
  output logic [WORD_SIZE-1:0]           redirect_pc,
  output logic                           halted
);

  typedef enum logic [1:0] {
    KIND_REG    = 2'b00,
    KIND_STORE  = 2'b01,
    KIND_BRANCH = 2'b10,
    KIND_HALT   = 2'b11
  } kind_e;

  localparam logic [RB_INDEX:0]   CNT_ONE = (RB_INDEX+1)'(1);
  localparam logic [RB_INDEX:0]   CNT_MAX = (RB_INDEX+1)'(RB_SIZE);
  localparam logic [RB_INDEX-1:0] PTR_ONE = RB_INDEX'(1);

  // Pointers and occupancy
  logic [RB_INDEX-1:0] head_q, head_d, tail_q, tail_d;
  logic [RB_INDEX:0]   count_q, count_d;

  // Entry storage
  logic [RB_SIZE-1:0]   valid_q, valid_d, done_q, done_d;
  kind_e                kind_q  [RB_SIZE];
  kind_e                kind_d  [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_q [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_d [RB_SIZE];
  logic [WORD_SIZE-1:0] data_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] data_d  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_d  [RB_SIZE];

  // Registered outputs
  logic [COMMIT_W-1:0]           commit_valid_q, commit_valid_d;
  logic [COMMIT_W*2-1:0]         commit_kind_q, commit_kind_d;
  logic [COMMIT_W*REG_INDEX-1:0] commit_rdest_q, commit_rdest_d;
  logic [COMMIT_W*WORD_SIZE-1:0] commit_data_q, commit_data_d;
  logic [COMMIT_W*WORD_SIZE-1:0] commit_addr_q, commit_addr_d;
  logic [COMMIT_W*RB_INDEX-1:0]  commit_idx_q, commit_idx_d;
  logic                          flush_q, flush_d;
  logic [WORD_SIZE-1:0]          redirect_pc_q, redirect_pc_d;
  logic                          halted_q, halted_d;

  // Per-port views of the writeback buses
  logic [RB_INDEX-1:0]  wbi [CDB_PORTS];
  logic [WORD_SIZE-1:0] wbd [CDB_PORTS];
  logic [WORD_SIZE-1:0] wba [CDB_PORTS];

  // Branch resolution and retirement scan
  logic                 flush_cond;
  logic [RB_INDEX-1:0]  br_idx, br_age;
  logic [WORD_SIZE-1:0] br_addr;
  logic [COMMIT_W-1:0]  ret_slot;
  logic [RB_INDEX:0]    n_ret;
  logic                 halt_ret;
  logic                 ret_scan;
  logic [RB_INDEX-1:0]  r_idx;
  logic                 alloc_fire;

  // Distance of an entry from the head, i.e. its age in program order
  function automatic logic [RB_INDEX-1:0] age(input logic [RB_INDEX-1:0] idx,
                                              input logic [RB_INDEX-1:0] hd);
    return idx - hd;
  endfunction

  // Split the packed writeback buses per port
  always_comb begin
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      wbi[p] = wb_idx[p*RB_INDEX +: RB_INDEX];
      wbd[p] = wb_data[p*WORD_SIZE +: WORD_SIZE];
      wba[p] = wb_addr[p*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Find the oldest taken branch written back this cycle
  always_comb begin
    flush_cond = 1'b0;
    br_idx     = '0;
    br_age     = '0;
    br_addr    = '0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (wb_valid[p] && valid_q[wbi[p]] && kind_q[wbi[p]] == KIND_BRANCH && wbd[p][0]) begin
        if (!flush_cond || age(wbi[p], head_q) < br_age) begin
          flush_cond = 1'b1;
          br_idx     = wbi[p];
          br_age     = age(wbi[p], head_q);
          br_addr    = wba[p];
        end
      end
    end
  end

  // In-order retirement scan over the head window, building the commit slots
  always_comb begin
    ret_slot       = '0;
    n_ret          = '0;
    halt_ret       = 1'b0;
    ret_scan       = !halted_q;
    r_idx          = '0;
    commit_valid_d = '0;
    commit_kind_d  = '0;
    commit_rdest_d = '0;
    commit_data_d  = '0;
    commit_addr_d  = '0;
    commit_idx_d   = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      r_idx = head_q + RB_INDEX'(k);
      if (ret_scan && valid_q[r_idx] && done_q[r_idx]
          && (kind_q[r_idx] != KIND_STORE || (k == 0 && mem_ready))
          && (!flush_cond || RB_INDEX'(k) <= br_age)) begin
        ret_slot[k] = 1'b1;
        n_ret       = n_ret + CNT_ONE;
        commit_kind_d [k*2 +: 2]                 = kind_q[r_idx];
        commit_rdest_d[k*REG_INDEX +: REG_INDEX] = rdest_q[r_idx];
        commit_data_d [k*WORD_SIZE +: WORD_SIZE] = data_q[r_idx];
        commit_addr_d [k*WORD_SIZE +: WORD_SIZE] = addr_q[r_idx];
        commit_idx_d  [k*RB_INDEX +: RB_INDEX]   = r_idx;
        if (kind_q[r_idx] == KIND_HALT) halt_ret = 1'b1;
        // A halt or a store takes the cycle to itself: nothing younger retires with it
        if (kind_q[r_idx] == KIND_HALT || kind_q[r_idx] == KIND_STORE) ret_scan = 1'b0;
      end else begin
        ret_scan = 1'b0;
      end
    end
    commit_valid_d = ret_slot;
  end

  // Entry state update: writeback, then retire, squash and allocate
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    kind_d  = kind_q;
    rdest_d = rdest_q;
    data_d  = data_q;
    addr_d  = addr_q;
    // Highest port applied first so the lowest port's write lands last and wins
    for (int unsigned p = CDB_PORTS; p > 0; p--) begin
      if (wb_valid[p-1] && valid_q[wbi[p-1]]
          && !(flush_cond && age(wbi[p-1], head_q) > br_age)) begin
        done_d[wbi[p-1]] = 1'b1;
        data_d[wbi[p-1]] = wbd[p-1];
        addr_d[wbi[p-1]] = wba[p-1];
      end
    end
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (ret_slot[k]) begin
        valid_d[head_q + RB_INDEX'(k)] = 1'b0;
        done_d [head_q + RB_INDEX'(k)] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < RB_SIZE; i++) begin
      if (flush_cond && age(RB_INDEX'(i), head_q) > br_age) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = (alloc_kind == KIND_HALT);
      kind_d[tail_q]  = kind_e'(alloc_kind);
      rdest_d[tail_q] = alloc_rdest;
      data_d[tail_q]  = '0;
      addr_d[tail_q]  = '0;
    end
  end

  // Allocation handshake, pointer/count update and flush/halt outputs
  always_comb begin
    alloc_ready = (count_q < CNT_MAX) && !halted_q && !flush_cond;
    alloc_fire  = alloc_valid && alloc_ready;
    alloc_idx   = tail_q;
    head_d      = head_q + n_ret[RB_INDEX-1:0];
    if (flush_cond) begin
      tail_d  = br_idx + PTR_ONE;
      count_d = {1'b0, br_age} + CNT_ONE - n_ret;
    end else if (alloc_fire) begin
      tail_d  = tail_q + PTR_ONE;
      count_d = count_q + CNT_ONE - n_ret;
    end else begin
      tail_d  = tail_q;
      count_d = count_q - n_ret;
    end
    flush_d       = flush_cond;
    redirect_pc_d = flush_cond ? br_addr : redirect_pc_q;
    halted_d      = halted_q | halt_ret;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      for (int unsigned i = 0; i < RB_SIZE; i++) begin
        kind_q[i]  <= KIND_REG;
        rdest_q[i] <= '0;
        data_q[i]  <= '0;
        addr_q[i]  <= '0;
      end
      commit_valid_q <= '0;
      commit_kind_q  <= '0;
      commit_rdest_q <= '0;
      commit_data_q  <= '0;
      commit_addr_q  <= '0;
      commit_idx_q   <= '0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
      halted_q       <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      kind_q         <= kind_d;
      rdest_q        <= rdest_d;
      data_q         <= data_d;
      addr_q         <= addr_d;
      commit_valid_q <= commit_valid_d;
      commit_kind_q  <= commit_kind_d;
      commit_rdest_q <= commit_rdest_d;
      commit_data_q  <= commit_data_d;
      commit_addr_q  <= commit_addr_d;
      commit_idx_q   <= commit_idx_d;
      flush_q        <= flush_d;
      redirect_pc_q  <= redirect_pc_d;
      halted_q       <= halted_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_kind  = commit_kind_q;
  assign commit_rdest = commit_rdest_q;
  assign commit_data  = commit_data_q;
  assign commit_addr  = commit_addr_q;
  assign commit_idx   = commit_idx_q;
  assign flush        = flush_q;
  assign redirect_pc  = redirect_pc_q;
  assign halted       = halted_q;

endmodule
